dma_copy_engine: RTL and testbench
==================================

// Module: dma_copy_engine
// PURPOSE
//  Memory-side initiator that drives the 16-bit data memory port (mem_addr/wr_data/rd_en/wr_en, rd_data back).
//  Performs block COPY (src->dst, ascending) or block FILL (constant->dst) of LEN words, started by a pulse from the control path.
//  Sits beside the CPU's load/store path; the CPU-side mux grants the memory port to this block while busy=1.
// PARAMETERS
//  ADDR_W     16    memory address width (matches data memory mem_addr)
//  DATA_W     16    memory data width
//  MEM_DEPTH  1024  number of valid words; addresses >= MEM_DEPTH are out of range
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request pulse; sampled only in IDLE
//  mode       in   1       0 = COPY, 1 = FILL; latched at start
//  src_addr   in   ADDR_W  first source word (COPY only); latched at start
//  dst_addr   in   ADDR_W  first destination word; latched at start
//  len        in   ADDR_W  word count; latched at start
//  fill_val   in   DATA_W  FILL pattern; latched at start
//  abort      in   1       terminate an active transfer
//  busy       out  1       1 while in RD or WR
//  done       out  1       1-cycle pulse on successful completion
//  err        out  1       1-cycle pulse on range error or abort
//  mem_addr   out  ADDR_W  memory address
//  wr_data    out  DATA_W  memory write data
//  rd_en      out  1       memory read enable (memory read is combinational, same cycle)
//  wr_en      out  1       memory write enable (memory writes on next rising clk)
//  rd_data    in   DATA_W  memory read data
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, rd_en, wr_en = 0; mem_addr, wr_data = 0; internal pointers, count, data_reg = 0.
//  Moore outputs decoded from the state register. In IDLE/DONE/ERR: mem_addr=0, wr_data=0, rd_en=wr_en=0.
//  States: IDLE, RD, WR, DONE, ERR.
//  IDLE: on start, latch inputs; range check uses ADDR_W+1-bit sums:
//   - len==0 -> DONE (done pulse, no memory access).
//   - dst_addr+len > MEM_DEPTH, or (COPY and src_addr+len > MEM_DEPTH) -> ERR; no memory access.
//   - otherwise COPY -> RD, FILL -> WR.
//  RD: mem_addr=src_ptr, rd_en=1; rd_data captured into data_reg on the edge leaving RD; -> WR.
//  WR: mem_addr=dst_ptr, wr_en=1, wr_data = data_reg (COPY) or fill_val latched (FILL).
//   On exit: dst_ptr+1, src_ptr+1 (COPY), count-1. count==1 -> DONE; else COPY -> RD, FILL stays in WR.
//  DONE: done=1 for exactly one cycle -> IDLE. ERR: err=1 for exactly one cycle -> IDLE.
//  Timing (start sampled at edge 0): COPY N words busy for 2N cycles, done in cycle 2N+1.
//   FILL N words busy for N cycles, done in cycle N+1.
//  abort in RD or WR -> ERR at next edge; a WR cycle with abort still commits its write (wr_en already high).
//   abort outside RD/WR is ignored.
//  start while not IDLE is ignored (no queueing). abort and start together in IDLE: start wins.
//  Overlapping COPY with dst>src propagates earlier words (ascending order, by design; not detected).
//  Pointers never wrap: the range check guarantees pointer < MEM_DEPTH.
//  Async reset mid-transfer: immediate return to reset values; partial writes stay in memory; no done/err.
// STRUCTURE
//  Package dma_pkg: state enum (IDLE, RD, WR, DONE, ERR), MODE_COPY/MODE_FILL constants, default ADDR_W/DATA_W/MEM_DEPTH.
//  Sub-module dma_range_check (combinational): base, len, MEM_DEPTH -> ok; one instance for src, one for dst.
//  Top holds the FSM, latched pointers, count, data_reg and the output decode.
// TESTING (bench: engine connected to a data-memory model preloaded with mem[i] = 16'hA000+i)
//  1. COPY src=0x010, dst=0x100, len=4 -> mem[0x100..0x103] = A010..A013; busy for 8 cycles; done in cycle 9; err=0.
//  2. FILL dst=0x200, len=3, fill_val=0xBEEF -> mem[0x200..0x202] = BEEF; rd_en never 1; done in cycle 4.
//  3. len=0 -> done pulse in cycle 1; busy, rd_en, wr_en never 1.
//  4. Range errors:
//   - COPY src=0x3FE, len=3 -> err pulse in cycle 1; no wr_en.
//   - dst=0x3FD, len=3 -> accepted; mem[0x3FD..0x3FF] written.
//  5. COPY len=8, abort asserted during the 3rd WR cycle -> exactly 3 words written; err pulse next cycle; done never 1.
//  6. start re-pulsed while busy is ignored; rst_n low during a FILL -> outputs 0 asynchronously; the next start runs normally.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, mode constants and default sizes for the copy engine
package dma_pkg;
  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_MEM_DEPTH = 1024;
endpackage

// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if: data memory port shared between the engine (master) and the memory (slave)
interface dma_copy_engine_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic rd_en;
  logic wr_en;
  modport master(output mem_addr, wr_data, rd_en, wr_en, input rd_data);
  modport slave(input mem_addr, wr_data, rd_en, wr_en, output rd_data);
endinterface

// File: rtl/dma_range_check.sv
// dma_range_check: flags whether a block of len words starting at base stays inside the memory
module dma_range_check #(
  parameter int ADDR_W = 16,
  parameter int MEM_DEPTH = 1024
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic              ok
);
  logic [ADDR_W:0] last_excl;
  assign last_excl = {1'b0, base} + {1'b0, len};
  assign ok = last_excl <= (ADDR_W+1)'(MEM_DEPTH);
endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: block COPY/FILL initiator on the data memory port with range check and abort
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  dma_copy_engine_if.master mem
);
  state_t            state;
  logic              mode_q;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] fill_q;
  logic              src_ok;
  logic              dst_ok;
  dma_range_check #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_src_chk (.base(src_addr), .len(len), .ok(src_ok));
  dma_range_check #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_dst_chk (.base(dst_addr), .len(len), .ok(dst_ok));
  // FSM; outputs are registered for the state being entered, so they track the state register.
  // The wr_data register doubles as the read-data capture register on the RD->WR edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= MODE_COPY;
      src_ptr <= '0;
      dst_ptr <= '0;
      count <= '0;
      fill_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem.rd_en <= 1'b0;
      mem.wr_en <= 1'b0;
      mem.mem_addr <= '0;
      mem.wr_data <= '0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem.rd_en <= 1'b0;
      mem.wr_en <= 1'b0;
      mem.mem_addr <= '0;
      mem.wr_data <= '0;
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          src_ptr <= src_addr;
          dst_ptr <= dst_addr;
          count <= len;
          fill_q <= fill_val;
          if (len == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else if (!dst_ok || (mode == MODE_COPY && !src_ok)) begin
            state <= ERR;
            err <= 1'b1;
          end else if (mode == MODE_COPY) begin
            state <= RD;
            busy <= 1'b1;
            mem.rd_en <= 1'b1;
            mem.mem_addr <= src_addr;
          end else begin
            state <= WR;
            busy <= 1'b1;
            mem.wr_en <= 1'b1;
            mem.mem_addr <= dst_addr;
            mem.wr_data <= fill_val;
          end
        end
        RD: if (abort) begin
          state <= ERR;
          err <= 1'b1;
        end else begin
          state <= WR;
          busy <= 1'b1;
          mem.wr_en <= 1'b1;
          mem.mem_addr <= dst_ptr;
          mem.wr_data <= mem.rd_data;
        end
        WR: begin
          dst_ptr <= dst_ptr + 1'b1;
          src_ptr <= (mode_q == MODE_COPY) ? src_ptr + 1'b1 : src_ptr;
          count <= count - 1'b1;
          if (abort) begin
            state <= ERR;
            err <= 1'b1;
          end else if (count == ADDR_W'(1)) begin
            state <= DONE;
            done <= 1'b1;
          end else if (mode_q == MODE_COPY) begin
            state <= RD;
            busy <= 1'b1;
            mem.rd_en <= 1'b1;
            mem.mem_addr <= src_ptr + 1'b1;
          end else begin
            busy <= 1'b1;
            mem.wr_en <= 1'b1;
            mem.mem_addr <= dst_ptr + 1'b1;
            mem.wr_data <= fill_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed and random COPY/FILL runs against a memory model and an array-level reference
module tb_dma_copy_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic [15:0] fill_val = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] mem [1024];
  logic [15:0] ref_mem [1024];
  int          checks = 0;
  int          errors = 0;

  dma_copy_engine_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  dma_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .abort(abort), .busy(busy), .done(done), .err(err), .mem(mem_if.master)
  );

  always #5 clk = ~clk;

  // data memory: combinational read, write on rising edge
  assign mem_if.rd_data = mem[mem_if.mem_addr[9:0]];
  always @(posedge clk) if (mem_if.wr_en) mem[mem_if.mem_addr[9:0]] <= mem_if.wr_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic run_op(input logic m, input int src, input int dst, input int n,
                        input logic [15:0] fv, input int abort_k, input bit repulse);
    logic [15:0] wq [$];
    int words, exp_busy, exp_end, busy_c, rd_c, wr_c, bad, end_c, c;
    bit exp_err, got_done, got_err;
    bit rng = (dst + n > 1024) || (m == 1'b0 && src + n > 1024);
    exp_err = 0;
    words = 0;
    if (n == 0) begin
      exp_end = 1;
    end else if (rng) begin
      exp_err = 1;
      exp_end = 1;
    end else begin
      words = (abort_k > 0 && abort_k < n) ? abort_k : n;
      exp_err = (abort_k > 0 && abort_k < n);
      exp_end = (m ? words : 2 * words) + 1;
    end
    exp_busy = (words == 0) ? 0 : exp_end - 1;
    for (int i = 0; i < words; i++) begin
      wq.push_back(m ? fv : ref_mem[src + i]);
      ref_mem[dst + i] = wq[i];
    end
    @(negedge clk);
    mode = m;
    src_addr = 16'(src);
    dst_addr = 16'(dst);
    len = 16'(n);
    fill_val = fv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_c = 0; rd_c = 0; wr_c = 0; bad = 0; end_c = 0; got_done = 0; got_err = 0;
    for (c = 1; c <= 2100; c++) begin
      abort = 1'b0;
      if (c == 4) start = 1'b0;
      if (busy) busy_c++;
      if (mem_if.rd_en) begin
        if (mem_if.mem_addr !== 16'(src + rd_c)) bad++;
        rd_c++;
      end
      if (mem_if.wr_en) begin
        if (mem_if.mem_addr !== 16'(dst + wr_c) || wr_c >= words || mem_if.wr_data !== wq[wr_c]) bad++;
        wr_c++;
        if (wr_c == abort_k) abort = 1'b1;
      end
      if (done || err) begin
        got_done = done;
        got_err = err;
        end_c = c;
        check("idle_bus", {mem_if.mem_addr, mem_if.wr_data}, 32'h0);
        check("idle_en", {busy, mem_if.rd_en, mem_if.wr_en}, 32'h0);
        break;
      end
      if (repulse && c == 3) begin
        mode = 1'b1; dst_addr = 16'h0; len = 16'd5; fill_val = 16'hDEAD; start = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    check("end_cycle", end_c, exp_end);
    check("done", got_done, !exp_err);
    check("err", got_err, exp_err);
    check("busy_cycles", busy_c, exp_busy);
    check("rd_cycles", rd_c, m ? 0 : words);
    check("wr_cycles", wr_c, words);
    check("bus_seq_bad", bad, 0);
    @(negedge clk);
    check("pulse_len", {done, err, busy}, 32'h0);
    check("mem_diffs", mem_diffs(), 0);
  endtask

  initial begin
    int m, n, s, d, k;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'hA000 + 16'(i);
      ref_mem[i] = 16'hA000 + 16'(i);
    end
    #12;
    check("rst_outs", {busy, done, err, mem_if.rd_en, mem_if.wr_en}, 32'h0);
    check("rst_bus", {mem_if.mem_addr, mem_if.wr_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 'h010, 'h100, 4, 16'h0, 0, 0);
    check("copy_first", mem[16'h100], 16'hA010);
    check("copy_last", mem[16'h103], 16'hA013);
    run_op(1'b1, 0, 'h200, 3, 16'hBEEF, 0, 0);
    check("fill_last", mem[16'h202], 16'hBEEF);
    run_op(1'b0, 5, 6, 0, 16'h0, 0, 0);
    run_op(1'b0, 'h3FE, 'h000, 3, 16'h0, 0, 0);
    run_op(1'b0, 'h020, 'h3FD, 3, 16'h0, 0, 0);
    check("edge_write", mem[16'h3FF], 16'hA022);
    run_op(1'b0, 'h040, 'h140, 8, 16'h0, 3, 0);
    check("abort_tail", mem[16'h143], 16'hA143);
    run_op(1'b0, 'h060, 'h160, 5, 16'h0, 0, 1);
    // async reset in the middle of a FILL: four writes committed, the fifth never lands
    @(negedge clk);
    mode = 1'b1; dst_addr = 16'h300; len = 16'd10; fill_val = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) ref_mem['h300 + i] = 16'h1234;
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {busy, done, err, mem_if.rd_en, mem_if.wr_en}, 32'h0);
    check("arst_bus", {mem_if.mem_addr, mem_if.wr_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_mem", mem_diffs(), 0);
    run_op(1'b1, 0, 'h310, 2, 16'h5A5A, 0, 0);
    for (int t = 0; t < 8; t++) begin
      m = $urandom_range(0, 1);
      n = $urandom_range(0, 12);
      s = $urandom_range(0, 1023);
      d = ($urandom_range(0, 2) == 0) ? s + $urandom_range(0, 3) : $urandom_range(0, 1023);
      if (d > 1023) d = 1023;
      k = ($urandom_range(0, 2) == 0 && n > 1) ? $urandom_range(1, n - 1) : 0;
      run_op(m[0], s, d, n, 16'($urandom), k, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
